// File: rtl/pkt_serializer_fifo_if.sv
// rtl/pkt_serializer_fifo_if.sv - result strobe and packet FIFO read port bundle
interface pkt_serializer_fifo_if #(
  parameter int N_WORDS = 4,
  parameter int WORD_W  = 16,
  parameter int DEPTH   = 64
);
  logic [N_WORDS*WORD_W-1:0] i_pkt_data;
  logic                      i_pkt_valid;
  logic                      o_pkt_dropped;
  logic [7:0]                o_pktfifo_data;
  logic                      o_pktfifo_empty;
  logic                      i_pktfifo_pop;
  logic [$clog2(DEPTH):0]    o_nBytes;

  modport slave (
    input  i_pkt_data, i_pkt_valid, i_pktfifo_pop,
    output o_pkt_dropped, o_pktfifo_data, o_pktfifo_empty, o_nBytes
  );

  modport master (
    output i_pkt_data, i_pkt_valid, i_pktfifo_pop,
    input  o_pkt_dropped, o_pktfifo_data, o_pktfifo_empty, o_nBytes
  );
endinterface

// File: rtl/pkt_serializer_fifo.sv
// rtl/pkt_serializer_fifo.sv - frames result vectors into header+payload bytes in an FWFT byte FIFO
module pkt_serializer_fifo #(
  parameter int N_WORDS = 4,
  parameter int WORD_W  = 16,
  parameter int DEPTH   = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cg,
  pkt_serializer_fifo_if.slave  bus
);
  localparam int WORD_B  = (WORD_W + 7) / 8;
  localparam int PAY_B   = N_WORDS * WORD_B;
  localparam int PKT_LEN = 1 + PAY_B;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int BW      = $clog2(PKT_LEN + 1);
  localparam logic [CW-1:0] MAX_FILL = CW'(DEPTH - PKT_LEN);

  typedef enum logic {ST_IDLE, ST_SERIALIZE} state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [PAY_B*8-1:0]   shift_q, shift_d, pay_bytes;
  logic [6:0]           seq_q, seq_d;
  logic                 drop_flag_q, drop_flag_d;
  logic                 dropped_q, dropped_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [7:0]           mem [DEPTH];
  logic                 push, pop, has_room;
  logic [7:0]           wr_byte;

  // Each word is zero-padded to whole bytes so the shift register emits LSB-first per word.
  always_comb begin
    pay_bytes = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      pay_bytes[k*WORD_B*8 +: WORD_W] = bus.i_pkt_data[k*WORD_W +: WORD_W];
    end
  end

  // Room for a whole packet is reserved at accept; later pops only add space.
  assign has_room = (count_q <= MAX_FILL);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    seq_d       = seq_q;
    drop_flag_d = drop_flag_q;
    dropped_d   = dropped_q;
    push        = 1'b0;
    wr_byte     = shift_q[7:0];
    pop         = i_cg && bus.i_pktfifo_pop && (count_q != '0);
    if (i_cg) begin
      dropped_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.i_pkt_valid) begin
            if (has_room) begin
              push        = 1'b1;
              wr_byte     = {drop_flag_q, seq_q};
              shift_d     = pay_bytes;
              seq_d       = seq_q + 7'd1;
              drop_flag_d = 1'b0;
              cnt_d       = BW'(PKT_LEN - 1);
              state_d     = ST_SERIALIZE;
            end else begin
              dropped_d   = 1'b1;
              drop_flag_d = 1'b1;
            end
          end
        end
        ST_SERIALIZE: begin
          push    = 1'b1;
          wr_byte = shift_q[7:0];
          shift_d = shift_q >> 8;
          cnt_d   = cnt_q - BW'(1);
          if (cnt_q == BW'(1)) begin
            state_d = ST_IDLE;
          end
          if (bus.i_pkt_valid) begin
            dropped_d   = 1'b1;
            drop_flag_d = 1'b1;
          end
        end
      endcase
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      seq_q       <= '0;
      drop_flag_q <= 1'b0;
      dropped_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      seq_q       <= seq_d;
      drop_flag_q <= drop_flag_d;
      dropped_q   <= dropped_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_byte;
    end
  end

  assign bus.o_pktfifo_data  = mem[rd_ptr_q];
  assign bus.o_pktfifo_empty = (count_q == '0);
  assign bus.o_nBytes        = count_q;
  assign bus.o_pkt_dropped   = dropped_q;
endmodule

// File: doc/pkt_serializer_fifo.md
Name: pkt_serializer_fifo

Overview:
- Upstream neighbour of the BytePipe register block: feeds its packet-FIFO read port (data/empty/pop).
- Captures one wide correlator result vector per strobe and frames it as a byte packet (header + payload).
- Buffers packet bytes in a first-word-fall-through byte FIFO for host readout over the BytePipe burst-read register.
- Drops whole packets when busy or short of space, never partial ones.

Parameters:
- N_WORDS, 4, result words per packet.
- WORD_W, 16, bits per result word; WORD_B = ceil(WORD_W/8) bytes per word.
- DEPTH, 64, FIFO depth in bytes; power of 2; must be >= PKT_LEN = 1 + N_WORDS*WORD_B (9 at defaults).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  asynchronous active-high reset.
- i_cg  input  1  clock-gate enable; when low no state changes.
- i_pkt_data  input  N_WORDS*WORD_W  result vector; word k is bits [k*WORD_W +: WORD_W].
- i_pkt_valid  input  1  single-cycle strobe; no ready, may be dropped.
- o_pkt_dropped  output  1  one-cycle pulse, strobe rejected.
- o_pktfifo_data  output  8  head byte, FWFT.
- o_pktfifo_empty  output  1  FIFO holds no bytes.
- i_pktfifo_pop  input  1  consume head byte.
- o_nBytes  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, i_rst high):
  - o_pktfifo_empty=1, o_nBytes=0, o_pkt_dropped=0.
  - State IDLE; seq=0; dropFlag=0.
  - Storage array is not reset.
  - Reset mid-packet discards the partial packet and all buffered bytes.
- All updates occur only on cycles with i_cg=1. Strobes and pops while i_cg=0 are ignored; no drop pulse.
- Accept condition: i_pkt_valid && state==IDLE && (DEPTH - o_nBytes) >= PKT_LEN.
  - Else, if i_pkt_valid: drop. o_pkt_dropped=1 the next cycle and dropFlag is set.
- On accept (edge t):
  - Header byte {dropFlag, seq[6:0]} is written to FIFO.
  - Payload is captured into a shift register.
  - seq increments, wrapping 127->0; dropFlag clears.
  - State becomes SERIALIZE with byte counter = PKT_LEN-1.
- SERIALIZE: one payload byte is written per enabled cycle; the counter decrements.
  - Byte order: word 0 first; within a word, least significant byte first.
  - Bits above WORD_W in the top byte are zero.
  - After the last payload byte is written, state returns to IDLE. A strobe is acceptable in that next IDLE cycle, so the maximum rate is one packet per PKT_LEN cycles.
- Space reservation is checked only at accept. Payload writes never overflow, since pops can only add space.
- FIFO:
  - A write at edge t makes the byte visible (empty=0) after edge t: one-cycle latency from accept to the header being visible.
  - o_pktfifo_data is valid whenever empty=0; it is don't-care when empty.
  - A pop while empty is ignored (no underflow; o_nBytes stays 0).
  - Simultaneous push and pop: occupancy unchanged, order preserved, including when occupancy is 1.
  - Pointers wrap modulo DEPTH.
  - o_nBytes ranges 0..DEPTH.
- Pop-when-not-empty removes the head; the next byte appears on the following cycle.

Test Plan:
- Reset, one strobe with words 0x1234, 0xABCD, 0x0001, 0xFFFF -> 9 bytes popped: 00 34 12 CD AB 01 00 FF FF; header visible 1 cycle after strobe; o_nBytes peaks at 9.
- Second strobe 3 cycles after the first (SERIALIZE) -> o_pkt_dropped pulses once. Third strobe after IDLE -> header 0x81 (dropFlag=1, seq=1). Fourth strobe -> header 0x02.
- No pops; strobe every 9 cycles from empty -> 7 packets accepted (63 bytes); the 8th strobe (free=1) is dropped; o_nBytes=63.
- Continuous pop while writing 130 packets -> headers' seq field wraps 127->0; bytes ordered; no drops; o_nBytes never exceeds 9.
- Assert i_rst mid-SERIALIZE (after 4 bytes written) -> empty=1 and o_nBytes=0 immediately; next packet's header is 0x00.
- i_cg=0 for 5 cycles during SERIALIZE with pops asserted -> no bytes written or popped and o_nBytes frozen; resumes correctly when i_cg=1.
